// File: rtl/dcache_banked.sv
// rtl/dcache_banked.sv - banked single-port data cache shared by load, store, DMA read and DMA write
//
// Purpose: 2**LOG_BANKS single-port SRAM banks, selected by the low address bits,
// arbitrated per bank every cycle with priority dw > st > ld > dr. A DMA read denied
// STARVE_MAX cycles in a row is promoted to top priority. Reads have 1-cycle latency.
//
// Ports:
//   clk, reset (sync, active-high), freeze (holds all state, no grants)
//   ld_*  : cisa load request (valid/slot/addr), ready, rvalid/rdata response
//   st_*  : cisa store request (valid/slot/addr/data), ready
//   dr_*  : DMA read request (valid/slot/addr/tag), ready, rvalid/rdata/rtag response
//   dw_*  : DMA write request (valid/slot/addr/data), ready
//   conflict_cnt : saturating count of cycles with at least one denied valid request
//
// Optional feature macro DCACHE_BANKED_FORWARD_EN: a ld or dr that loses its bank to a
// granted write at the identical {slot, addr} is granted as well and returns the write data.
module dcache_banked #(
   parameter int BITS       = 18,
   parameter int SLOT_W     = 2,
   parameter int ADDR_W     = 5,
   parameter int LOG_BANKS  = 2,
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              freeze,
   input  logic              ld_valid,
   input  logic [SLOT_W-1:0] ld_slot,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_ready,
   output logic              ld_rvalid,
   output logic [BITS-1:0]   ld_rdata,
   input  logic              st_valid,
   input  logic [SLOT_W-1:0] st_slot,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [BITS-1:0]   st_data,
   output logic              st_ready,
   input  logic              dr_valid,
   input  logic [SLOT_W-1:0] dr_slot,
   input  logic [ADDR_W-1:0] dr_addr,
   input  logic [3:0]        dr_tag,
   output logic              dr_ready,
   output logic              dr_rvalid,
   output logic [BITS-1:0]   dr_rdata,
   output logic [3:0]        dr_rtag,
   input  logic              dw_valid,
   input  logic [SLOT_W-1:0] dw_slot,
   input  logic [ADDR_W-1:0] dw_addr,
   input  logic [BITS-1:0]   dw_data,
   output logic              dw_ready,
   output logic [CNT_W-1:0]  conflict_cnt
);
   localparam int NB    = 1 << LOG_BANKS;
   localparam int ROW_W = SLOT_W + ADDR_W - LOG_BANKS;
   localparam int DEPTH = 1 << ROW_W;
   localparam int SW    = $clog2(STARVE_MAX + 1);

   logic [BITS-1:0] mem [0:NB-1][0:DEPTH-1];

   logic [LOG_BANKS-1:0] ld_bank, st_bank, dr_bank, dw_bank;
   logic [ROW_W-1:0]     ld_row, st_row, dr_row, dw_row;

   assign ld_bank = ld_addr[LOG_BANKS-1:0];
   assign st_bank = st_addr[LOG_BANKS-1:0];
   assign dr_bank = dr_addr[LOG_BANKS-1:0];
   assign dw_bank = dw_addr[LOG_BANKS-1:0];
   assign ld_row  = {ld_slot, ld_addr[ADDR_W-1:LOG_BANKS]};
   assign st_row  = {st_slot, st_addr[ADDR_W-1:LOG_BANKS]};
   assign dr_row  = {dr_slot, dr_addr[ADDR_W-1:LOG_BANKS]};
   assign dw_row  = {dw_slot, dw_addr[ADDR_W-1:LOG_BANKS]};

   logic [SW-1:0]    starve_cnt;
   logic [BITS-1:0]  ld_rdata_q, dr_rdata_q;
   logic [3:0]       dr_rtag_q;
   logic             ld_rvalid_q, dr_rvalid_q;
   logic [CNT_W-1:0] conflict_q;

   logic active, dr_top;
   logic dw_win, st_win, ld_win, dr_win;
   logic ld_fwd, dr_fwd;
   logic [BITS-1:0] ld_fwd_data, dr_fwd_data;
   logic any_deny;

   always_comb begin
      active = !reset && !freeze;
      dr_top = dr_valid && (starve_cnt == SW'(STARVE_MAX));

      // A requester loses its bank to any higher-priority valid request there; a
      // promoted dr sits above everyone, so it also blocks dw.
      dw_win = dw_valid && !(dr_top && dr_bank == dw_bank);
      st_win = st_valid && !(dw_valid && dw_bank == st_bank)
                        && !(dr_top && dr_bank == st_bank);
      ld_win = ld_valid && !(dw_valid && dw_bank == ld_bank)
                        && !(st_valid && st_bank == ld_bank)
                        && !(dr_top && dr_bank == ld_bank);
      dr_win = dr_valid && (dr_top || !((dw_valid && dw_bank == dr_bank)
                                     || (st_valid && st_bank == dr_bank)
                                     || (ld_valid && ld_bank == dr_bank)));

      ld_fwd      = 1'b0;
      dr_fwd      = 1'b0;
      ld_fwd_data = st_data;
      dr_fwd_data = st_data;
`ifdef DCACHE_BANKED_FORWARD_EN
      // At most one of dw/st can win a given bank, so the data select is unambiguous.
      ld_fwd = ld_valid && !ld_win
               && ((dw_win && dw_slot == ld_slot && dw_addr == ld_addr)
                || (st_win && st_slot == ld_slot && st_addr == ld_addr));
      dr_fwd = dr_valid && !dr_win
               && ((dw_win && dw_slot == dr_slot && dw_addr == dr_addr)
                || (st_win && st_slot == dr_slot && st_addr == dr_addr));
      if (dw_win && dw_slot == ld_slot && dw_addr == ld_addr) ld_fwd_data = dw_data;
      if (dw_win && dw_slot == dr_slot && dw_addr == dr_addr) dr_fwd_data = dw_data;
`endif

      dw_ready = active && dw_win;
      st_ready = active && st_win;
      ld_ready = active && (ld_win || ld_fwd);
      dr_ready = active && (dr_win || dr_fwd);

      any_deny = (dw_valid && !dw_ready) || (st_valid && !st_ready)
              || (ld_valid && !ld_ready) || (dr_valid && !dr_ready);
   end

   // Bank array: readys already exclude reset and freeze, and two writes granted in
   // the same cycle are always to different banks.
   always_ff @(posedge clk) begin
      if (dw_ready) mem[dw_bank][dw_row] <= dw_data;
      if (st_ready) mem[st_bank][st_row] <= st_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ld_rvalid_q <= 1'b0;
         dr_rvalid_q <= 1'b0;
         ld_rdata_q  <= '0;
         dr_rdata_q  <= '0;
         dr_rtag_q   <= '0;
         starve_cnt  <= '0;
         conflict_q  <= '0;
      end else if (!freeze) begin
         ld_rvalid_q <= ld_ready;
         dr_rvalid_q <= dr_ready;
         if (ld_ready) ld_rdata_q <= ld_fwd ? ld_fwd_data : mem[ld_bank][ld_row];
         if (dr_ready) begin
            dr_rdata_q <= dr_fwd ? dr_fwd_data : mem[dr_bank][dr_row];
            dr_rtag_q  <= dr_tag;
         end
         if (!dr_valid || dr_ready)
            starve_cnt <= '0;
         else if (starve_cnt != SW'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
         if (any_deny && conflict_q != '1)
            conflict_q <= conflict_q + 1'b1;
      end
   end

   // Masking with reset keeps a read granted just before reset from showing rvalid
   // during the reset cycle itself.
   assign ld_rvalid    = ld_rvalid_q && !reset;
   assign dr_rvalid    = dr_rvalid_q && !reset;
   assign ld_rdata     = reset ? '0 : ld_rdata_q;
   assign dr_rdata     = reset ? '0 : dr_rdata_q;
   assign dr_rtag      = reset ? '0 : dr_rtag_q;
   assign conflict_cnt = conflict_q;
endmodule

// File: tb/tb_dcache_banked.sv
// tb/tb_dcache_banked.sv - directed self-checking bench for dcache_banked
module tb_dcache_banked;
   logic        clk = 1'b0;
   logic        reset, freeze;
   logic        ld_valid, st_valid, dr_valid, dw_valid;
   logic [1:0]  ld_slot, st_slot, dr_slot, dw_slot;
   logic [4:0]  ld_addr, st_addr, dr_addr, dw_addr;
   logic [17:0] st_data, dw_data;
   logic [3:0]  dr_tag;
   logic        ld_ready, st_ready, dr_ready, dw_ready;
   logic        ld_rvalid, dr_rvalid;
   logic [17:0] ld_rdata, dr_rdata;
   logic [3:0]  dr_rtag;
   logic [15:0] conflict_cnt;

   int tests_run = 0;
   int fails = 0;
   logic [15:0] exp_conf = 16'd0;

   always #5 clk = ~clk;

   dcache_banked dut (
      .clk(clk), .reset(reset), .freeze(freeze),
      .ld_valid(ld_valid), .ld_slot(ld_slot), .ld_addr(ld_addr), .ld_ready(ld_ready),
      .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .st_valid(st_valid), .st_slot(st_slot), .st_addr(st_addr), .st_data(st_data),
      .st_ready(st_ready),
      .dr_valid(dr_valid), .dr_slot(dr_slot), .dr_addr(dr_addr), .dr_tag(dr_tag),
      .dr_ready(dr_ready), .dr_rvalid(dr_rvalid), .dr_rdata(dr_rdata), .dr_rtag(dr_rtag),
      .dw_valid(dw_valid), .dw_slot(dw_slot), .dw_addr(dw_addr), .dw_data(dw_data),
      .dw_ready(dw_ready),
      .conflict_cnt(conflict_cnt)
   );

   task automatic clear_valids();
      ld_valid = 0; st_valid = 0; dr_valid = 0; dw_valid = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1; freeze = 1;
      ld_valid = 1; ld_slot = 0; ld_addr = 1;
      st_valid = 1; st_slot = 0; st_addr = 2; st_data = 18'h3;
      dr_valid = 1; dr_slot = 0; dr_addr = 3; dr_tag = 4'h7;
      dw_valid = 1; dw_slot = 0; dw_addr = 0; dw_data = 18'h4;
      #1;
      tests_run++;
      if ({dw_ready, st_ready, ld_ready, dr_ready} !== 4'b0000) begin
         fails++; $display("FAIL reset_readys got %b exp 0000", {dw_ready, st_ready, ld_ready, dr_ready});
      end
      tick();
      tests_run++;
      if ({ld_rvalid, dr_rvalid, ld_rdata, dr_rdata, dr_rtag} !== 42'd0) begin
         fails++; $display("FAIL reset_outputs got %b %b %h %h %h exp all zero", ld_rvalid, dr_rvalid, ld_rdata, dr_rdata, dr_rtag);
      end
      @(negedge clk);
      reset = 0; freeze = 0; clear_valids();
      tick();
      tests_run++;
      if (conflict_cnt !== 16'd0) begin
         fails++; $display("FAIL reset_conflict got %0d exp 0", conflict_cnt);
      end
   endtask

   task automatic test_store_load();
      @(negedge clk);
      st_valid = 1; st_slot = 2; st_addr = 5; st_data = 18'h1ABCD;
      #1;
      tests_run++;
      if (st_ready !== 1'b1) begin
         fails++; $display("FAIL st_grant got %b exp 1", st_ready);
      end
      tick();
      @(negedge clk);
      st_valid = 0;
      ld_valid = 1; ld_slot = 2; ld_addr = 5;
      #1;
      tests_run++;
      if (ld_ready !== 1'b1) begin
         fails++; $display("FAIL ld_grant got %b exp 1", ld_ready);
      end
      tick();
      tests_run++;
      if ({ld_rvalid, ld_rdata} !== {1'b1, 18'h1ABCD}) begin
         fails++; $display("FAIL ld_data got %b %h exp 1 1abcd", ld_rvalid, ld_rdata);
      end
      @(negedge clk);
      ld_valid = 0;
      tick();
      tests_run++;
      if (ld_rvalid !== 1'b0) begin
         fails++; $display("FAIL ld_rvalid_pulse got %b exp 0", ld_rvalid);
      end
   endtask

   task automatic test_diff_banks();
      @(negedge clk);
      dw_valid = 1; dw_slot = 1; dw_addr = 2; dw_data = 18'h11111;
      st_valid = 1; st_slot = 1; st_addr = 3; st_data = 18'h22222;
      #1;
      tests_run++;
      if ({dw_ready, st_ready} !== 2'b11) begin
         fails++; $display("FAIL preload_grants got %b exp 11", {dw_ready, st_ready});
      end
      tick();
      @(negedge clk);
      dw_slot = 1; dw_addr = 0; dw_data = 18'h00033;
      st_slot = 1; st_addr = 1; st_data = 18'h00044;
      ld_valid = 1; ld_slot = 1; ld_addr = 2;
      dr_valid = 1; dr_slot = 1; dr_addr = 3; dr_tag = 4'h5;
      #1;
      tests_run++;
      if ({dw_ready, st_ready, ld_ready, dr_ready} !== 4'b1111) begin
         fails++; $display("FAIL four_bank_grants got %b exp 1111", {dw_ready, st_ready, ld_ready, dr_ready});
      end
      tick();
      tests_run++;
      if (conflict_cnt !== exp_conf) begin
         fails++; $display("FAIL four_bank_conflict got %0d exp %0d", conflict_cnt, exp_conf);
      end
      tests_run++;
      if ({ld_rvalid, ld_rdata, dr_rvalid, dr_rdata, dr_rtag} !== {1'b1, 18'h11111, 1'b1, 18'h22222, 4'h5}) begin
         fails++; $display("FAIL four_bank_reads got %b %h %b %h %h exp 1 11111 1 22222 5", ld_rvalid, ld_rdata, dr_rvalid, dr_rdata, dr_rtag);
      end
      @(negedge clk);
      clear_valids();
      tick();
   endtask

   task automatic test_same_bank();
      @(negedge clk);
      dw_valid = 1; dw_slot = 0; dw_addr = 5; dw_data = 18'h0F00F;
      tick();
      @(negedge clk);
      dw_valid = 0;
      st_valid = 1; st_slot = 0; st_addr = 1; st_data = 18'h0A5A5;
      ld_valid = 1; ld_slot = 0; ld_addr = 5;
      #1;
      tests_run++;
      if ({st_ready, ld_ready} !== 2'b10) begin
         fails++; $display("FAIL same_bank_grants got %b exp 10", {st_ready, ld_ready});
      end
      tick();
      exp_conf = exp_conf + 1;
      tests_run++;
      if (conflict_cnt !== exp_conf) begin
         fails++; $display("FAIL same_bank_conflict got %0d exp %0d", conflict_cnt, exp_conf);
      end
      @(negedge clk);
      st_valid = 0;
      #1;
      tests_run++;
      if (ld_ready !== 1'b1) begin
         fails++; $display("FAIL ld_retry_grant got %b exp 1", ld_ready);
      end
      tick();
      tests_run++;
      if ({ld_rvalid, ld_rdata} !== {1'b1, 18'h0F00F}) begin
         fails++; $display("FAIL ld_retry_data got %b %h exp 1 0f00f", ld_rvalid, ld_rdata);
      end
      @(negedge clk);
      clear_valids();
      tick();
   endtask

   task automatic test_starve();
      @(negedge clk);
      st_valid = 1; st_slot = 0; st_addr = 4; st_data = 18'h12345;
      tick();
      @(negedge clk);
      st_valid = 0;
      for (int i = 1; i <= 5; i++) begin
         if (i > 1) @(negedge clk);
         dw_valid = 1; dw_slot = 0; dw_addr = 0; dw_data = 18'(i);
         dr_valid = 1; dr_slot = 0; dr_addr = 4; dr_tag = 4'hA;
         #1;
         tests_run++;
         if (i < 5) begin
            if ({dw_ready, dr_ready} !== 2'b10) begin
               fails++; $display("FAIL starve_deny cycle %0d got %b exp 10", i, {dw_ready, dr_ready});
            end
         end else begin
            if ({dw_ready, dr_ready} !== 2'b01) begin
               fails++; $display("FAIL starve_promote got %b exp 01", {dw_ready, dr_ready});
            end
         end
         tick();
      end
      exp_conf = exp_conf + 5;
      tests_run++;
      if ({dr_rvalid, dr_rdata, dr_rtag} !== {1'b1, 18'h12345, 4'hA}) begin
         fails++; $display("FAIL starve_read got %b %h %h exp 1 12345 a", dr_rvalid, dr_rdata, dr_rtag);
      end
      tests_run++;
      if (conflict_cnt !== exp_conf) begin
         fails++; $display("FAIL starve_conflict got %0d exp %0d", conflict_cnt, exp_conf);
      end
      @(negedge clk);
      clear_valids();
      tick();
   endtask

   task automatic test_freeze();
      @(negedge clk);
      ld_valid = 1; ld_slot = 2; ld_addr = 5;
      tick();
      @(negedge clk);
      freeze = 1;
      dw_valid = 1; dw_slot = 3; dw_addr = 0; dw_data = 18'h00777;
      st_valid = 1; st_slot = 3; st_addr = 4; st_data = 18'h00888;
      ld_valid = 1; ld_slot = 3; ld_addr = 1;
      dr_valid = 1; dr_slot = 3; dr_addr = 5; dr_tag = 4'h2;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         tests_run++;
         if ({dw_ready, st_ready, ld_ready, dr_ready} !== 4'b0000) begin
            fails++; $display("FAIL freeze_readys cycle %0d got %b exp 0000", i, {dw_ready, st_ready, ld_ready, dr_ready});
         end
         tick();
         tests_run++;
         if ({ld_rvalid, ld_rdata, dr_rvalid, conflict_cnt} !== {1'b1, 18'h1ABCD, 1'b0, exp_conf}) begin
            fails++; $display("FAIL freeze_hold cycle %0d got %b %h %b %0d exp 1 1abcd 0 %0d", i, ld_rvalid, ld_rdata, dr_rvalid, conflict_cnt, exp_conf);
         end
      end
      @(negedge clk);
      freeze = 0;
      #1;
      tests_run++;
      if ({dw_ready, st_ready, ld_ready, dr_ready} !== 4'b1010) begin
         fails++; $display("FAIL unfreeze_winners got %b exp 1010", {dw_ready, st_ready, ld_ready, dr_ready});
      end
      tick();
      exp_conf = exp_conf + 1;
      tests_run++;
      if (conflict_cnt !== exp_conf) begin
         fails++; $display("FAIL unfreeze_conflict got %0d exp %0d", conflict_cnt, exp_conf);
      end
      @(negedge clk);
      clear_valids();
      tick();
   endtask

   task automatic test_forward();
      @(negedge clk);
      dw_valid = 1; dw_slot = 0; dw_addr = 8; dw_data = 18'h00F0F;
      dr_valid = 1; dr_slot = 0; dr_addr = 8; dr_tag = 4'h3;
      #1;
`ifdef DCACHE_BANKED_FORWARD_EN
      tests_run++;
      if ({dw_ready, dr_ready} !== 2'b11) begin
         fails++; $display("FAIL fwd_grants got %b exp 11", {dw_ready, dr_ready});
      end
      tick();
      tests_run++;
      if ({dr_rvalid, dr_rdata, dr_rtag, conflict_cnt} !== {1'b1, 18'h00F0F, 4'h3, exp_conf}) begin
         fails++; $display("FAIL fwd_data got %b %h %h %0d exp 1 00f0f 3 %0d", dr_rvalid, dr_rdata, dr_rtag, conflict_cnt, exp_conf);
      end
`else
      tests_run++;
      if ({dw_ready, dr_ready} !== 2'b10) begin
         fails++; $display("FAIL nofwd_grants got %b exp 10", {dw_ready, dr_ready});
      end
      tick();
      exp_conf = exp_conf + 1;
      tests_run++;
      if ({dr_rvalid, conflict_cnt} !== {1'b0, exp_conf}) begin
         fails++; $display("FAIL nofwd_conflict got %b %0d exp 0 %0d", dr_rvalid, conflict_cnt, exp_conf);
      end
`endif
      @(negedge clk);
      clear_valids();
      tick();
   endtask

   task automatic test_reset_midread();
      @(negedge clk);
      ld_valid = 1; ld_slot = 2; ld_addr = 5;
      #1;
      tests_run++;
      if (ld_ready !== 1'b1) begin
         fails++; $display("FAIL midread_grant got %b exp 1", ld_ready);
      end
      tick();
      @(negedge clk);
      ld_valid = 0; reset = 1;
      #1;
      tests_run++;
      if (ld_rvalid !== 1'b0) begin
         fails++; $display("FAIL midread_rvalid got %b exp 0", ld_rvalid);
      end
      tick();
      @(negedge clk);
      reset = 0;
      tick();
      tests_run++;
      if ({ld_rvalid, ld_rdata, conflict_cnt} !== {1'b0, 18'h0, 16'd0}) begin
         fails++; $display("FAIL midread_after got %b %h %0d exp 0 0 0", ld_rvalid, ld_rdata, conflict_cnt);
      end
   endtask

   initial begin
      reset = 1; freeze = 0;
      clear_valids();
      ld_slot = 0; ld_addr = 0; st_slot = 0; st_addr = 0; st_data = 0;
      dr_slot = 0; dr_addr = 0; dr_tag = 0; dw_slot = 0; dw_addr = 0; dw_data = 0;
      test_reset();
      test_store_load();
      test_diff_banks();
      test_same_bank();
      test_starve();
      test_freeze();
      test_forward();
      test_reset_midread();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule

// File: doc/dcache_banked.md
Name: dcache_banked

Overview:
- Parametrised successor to the single-slot dcache: N single-port SRAM banks shared by four requesters. The requesters are cisa_load, cisa_store, dma_read and dma_write.
- Bank is selected by the low address bits. Per-cycle fixed-priority arbitration, with a starvation guard for DMA reads.
- Replaces the combined regfile/DMA cache path between the regfile pipeline and the DMA engine. Adds valid/ready backpressure and a conflict counter for performance.

Parameters:
- BITS, 18, data word width
- SLOT_W, 2, slot field width; 2^SLOT_W slots
- ADDR_W, 5, word address width within a slot
- LOG_BANKS, 2, log2 of the bank count. Bank = addr[LOG_BANKS-1:0]; must be <= ADDR_W
- STARVE_MAX, 4, consecutive denied cycles before dma_read is promoted to top priority
- CNT_W, 16, width of the conflict counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- freeze  in  1  pipeline freeze. Holds all state; no grants.
- ld_valid  in  1  cisa load request
- ld_slot  in  SLOT_W  load slot
- ld_addr  in  ADDR_W  load address
- ld_ready  out  1  load granted this cycle (combinational)
- ld_rvalid  out  1  load data valid, 1 cycle after grant
- ld_rdata  out  BITS  load data
- st_valid  in  1  cisa store request
- st_slot / st_addr / st_data  in  SLOT_W / ADDR_W / BITS  store fields
- st_ready  out  1  store granted
- dr_valid  in  1  DMA read request
- dr_slot / dr_addr  in  SLOT_W / ADDR_W  DMA read fields
- dr_tag  in  4  opaque tag, returned with the data
- dr_ready  out  1  DMA read granted
- dr_rvalid / dr_rdata / dr_rtag  out  1 / BITS / 4  DMA read response, 1 cycle after grant
- dw_valid  in  1  DMA write request
- dw_slot / dw_addr / dw_data  in  SLOT_W / ADDR_W / BITS  DMA write fields
- dw_ready  out  1  DMA write granted
- conflict_cnt  out  CNT_W  saturating count of cycles in which at least one valid request was denied

Behaviour:
- Storage:
  - 2^LOG_BANKS banks, each single-port: one read or one write per cycle.
  - Row within a bank = {slot, addr[ADDR_W-1:LOG_BANKS]}.
  - Contents are not cleared by reset.
- Arbitration, evaluated per bank each cycle:
  - Base priority: dw > st > ld > dr.
  - When starve_cnt == STARVE_MAX, priority becomes dr > dw > st > ld.
  - Requests to different banks are all granted in the same cycle.
  - A requester's ready = valid && won its bank && !freeze && !reset.
  - A requester whose valid is high but ready is low must hold its fields stable; the block does not latch them.
- Writes: the bank is updated at the clk edge of the grant cycle.
- Reads:
  - The rdata/rtag register is loaded at the grant edge; rvalid is high for exactly the next cycle.
  - Read latency is 1.
  - A read granted in the cycle after a write to the same address returns the new data.
- starve_cnt:
  - Increments when dr_valid && !dr_ready && !freeze, saturating at STARVE_MAX.
  - Clears on a dr grant or when dr_valid is low.
- conflict_cnt: increments by 1 per non-frozen cycle with any valid && !ready; saturates at all-ones.
- freeze:
  - All readys are low.
  - rvalid outputs and rdata/rtag hold their values.
  - starve_cnt and conflict_cnt hold.
  - No bank access occurs.
- reset:
  - ld_rvalid = dr_rvalid = 0, ld_rdata = dr_rdata = 0, dr_rtag = 0.
  - starve_cnt = 0, conflict_cnt = 0.
  - All readys are low during reset.
  - Reset overrides freeze.
  - Reset mid-read: a read granted in the cycle before reset produces no rvalid.
- Same-bank, same-cycle: st and dw to the same bank → only dw writes. st is held off and retries; no write merging.

Optional Feature:
- Macro: DCACHE_BANKED_FORWARD_EN.
- Defined: a ld or dr request that loses its bank to a granted write (st or dw) at the identical {slot, addr} is also granted. It returns that write's data with normal 1-cycle latency, and the cycle does not count as a conflict for that requester.
- Not defined: such reads are denied and retry per normal arbitration.

Test Plan:
- Reset, then write via st slot 2 addr 5 = 18'h1ABCD; next cycle ld slot 2 addr 5 → ld_ready=1, next cycle ld_rvalid=1, ld_rdata=18'h1ABCD.
- Different banks (addr 0,1,2,3) on dw/st/ld/dr in the same cycle → all four readys = 1; conflict_cnt unchanged.
- st and ld both to bank 1 (addr 1 and 5) → st_ready=1, ld_ready=0, conflict_cnt +1; next cycle ld is granted.
- dw every cycle to bank 0 with dr held at addr 4 → dr denied 4 cycles, then granted on cycle 5 while dw_ready=0; dr_rtag echoed.
- freeze for 3 cycles with all valids high → all readys 0, rvalid/rdata/counters unchanged; after release, arbitration resumes with the same winners.
- With DCACHE_BANKED_FORWARD_EN: dw and dr both to slot 0 addr 8, data 18'h00F0F → both granted; next cycle dr_rdata=18'h00F0F. Without the macro: dr_ready=0 and conflict_cnt +1.
